mem_arbiter: RTL and testbench

Two-requester arbiter that shares one synchronous single-port 32-bit RAM between the processor's instruction-fetch path and its data-memory path. It lets the core run from a single unified memory instead of separate instruction and data RAMs. It sits between the PC/fetch logic and data-memory logic on one side and one `ram` instance on the other. It serialises accesses with a 3-state FSM and round-robin grant, and returns per-requester valid pulses that the core uses to stall.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side bus of the unified-memory arbiter.
// The slave modport is the arbiter; the master modport is the core/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_valid, if_rdata, dm_valid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_valid, if_rdata, dm_valid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between instruction fetch
// and data memory; one access per IDLE -> ACCESS -> RESP pass.
//
// state  | meaning
// IDLE   | no access in flight; grant decided here from if_req/dm_req
// ACCESS | mem_* driven with the granted request
// RESP   | read data captured, granted requester's valid pulse high
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_dm;
  logic              grant_dm;
  logic              pick_dm;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    // DM wins when alone, or on a tie when IF was granted last
    pick_dm   = bus.dm_req && (!bus.if_req || !last_dm);
    win_addr  = bus.if_addr;
    win_wdata = '0;
    if (pick_dm) begin
      win_addr  = bus.dm_addr;
      win_wdata = bus.dm_wdata;
    end
    case (state)
      IDLE: begin
        if (bus.if_req || bus.dm_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt = RESP;
        bus.busy  = 1'b1;
      end
      RESP: begin
        state_nxt = IDLE;
        bus.busy  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_dm       <= 1'b1;
      grant_dm      <= 1'b0;
      bus.if_valid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_valid  <= 1'b0;
      bus.dm_rdata  <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (state_nxt == ACCESS) begin
            grant_dm      <= pick_dm;
            last_dm       <= pick_dm;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= pick_dm & bus.dm_we;
            bus.mem_addr  <= win_addr;
            bus.mem_wdata <= win_wdata;
          end
        end
        ACCESS: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          if (grant_dm) begin
            bus.dm_valid <= 1'b1;
            // writes leave the last read value visible
            if (!bus.mem_we) bus.dm_rdata <= bus.mem_rdata;
          end else begin
            bus.if_valid <= 1'b1;
            bus.if_rdata <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected valid responses
// plus directed cycle checks per scenario.
module tb_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef struct {
    bit          dm;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  exp_t sb[$];
  exp_t e;
  logic [31:0] exp_dm;
  logic [31:0] got_data;
  logic [31:0] ram [0:1023];

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 | i;
  endfunction

  // RAM model responds on the falling edge inside the ACCESS cycle, so its
  // data is stable when the arbiter captures it at the next rising edge.
  always @(negedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
      else                     bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  // Scoreboard: every valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (bus.if_valid === 1'b1 || bus.dm_valid === 1'b1) begin
      tests_run++;
      if (bus.if_valid === 1'b1 && bus.dm_valid === 1'b1) begin
        tests_failed++;
        $display("FAIL both_valid if_valid=%0b dm_valid=%0b want not both", bus.if_valid, bus.dm_valid);
      end else if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_valid if_valid=%0b dm_valid=%0b want none", bus.if_valid, bus.dm_valid);
      end else begin
        e = sb.pop_front();
        got_data = (bus.dm_valid === 1'b1) ? bus.dm_rdata : bus.if_rdata;
        if (e.dm !== bus.dm_valid || e.data !== got_data) begin
          tests_failed++;
          $display("FAIL sb_txn got dm=%0b data=%h want dm=%0b data=%h", bus.dm_valid, got_data, e.dm, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit dm, input logic [31:0] data);
    exp_t x;
    x.dm   = dm;
    x.data = data;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++; if (bus.if_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_if_valid got %b want 0", bus.if_valid); end
    tests_run++; if (bus.dm_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_dm_valid got %b want 0", bus.dm_valid); end
    tests_run++; if (bus.if_rdata !== '0) begin tests_failed++; $display("FAIL rst_if_rdata got %h want 0", bus.if_rdata); end
    tests_run++; if (bus.dm_rdata !== '0) begin tests_failed++; $display("FAIL rst_dm_rdata got %h want 0", bus.dm_rdata); end
    tests_run++; if (bus.mem_en !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_en got %b want 0", bus.mem_en); end
    tests_run++; if (bus.mem_we !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_we got %b want 0", bus.mem_we); end
    tests_run++; if (bus.mem_addr !== '0) begin tests_failed++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); end
    tests_run++; if (bus.mem_wdata !== '0) begin tests_failed++; $display("FAIL rst_mem_wdata got %h want 0", bus.mem_wdata); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    reset = 1'b0;
    // first tie after reset goes to IF
    push(1'b0, pat(7));
    bus.if_req = 1'b1; bus.if_addr = 10'd7;
    bus.dm_req = 1'b1; bus.dm_addr = 10'd8; bus.dm_we = 1'b0;
    tick();
    tests_run++; if (bus.mem_addr !== 10'd7) begin tests_failed++; $display("FAIL tie_first_addr got %0d want 7", bus.mem_addr); end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_single_fetch();
    push(1'b0, 32'hDEADBEEF);
    bus.if_req = 1'b1; bus.if_addr = 10'd5;
    tick();
    tests_run++; if (bus.mem_en !== 1'b1) begin tests_failed++; $display("FAIL fetch_mem_en got %b want 1", bus.mem_en); end
    tests_run++; if (bus.mem_addr !== 10'd5) begin tests_failed++; $display("FAIL fetch_mem_addr got %0d want 5", bus.mem_addr); end
    tests_run++; if (bus.mem_we !== 1'b0) begin tests_failed++; $display("FAIL fetch_mem_we got %b want 0", bus.mem_we); end
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL fetch_busy got %b want 1", bus.busy); end
    bus.if_req = 1'b0;
    tick();
    tests_run++; if (bus.if_valid !== 1'b1) begin tests_failed++; $display("FAIL fetch_if_valid got %b want 1", bus.if_valid); end
    tests_run++; if (bus.if_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL fetch_if_rdata got %h want deadbeef", bus.if_rdata); end
    tests_run++; if (bus.dm_valid !== 1'b0) begin tests_failed++; $display("FAIL fetch_dm_valid got %b want 0", bus.dm_valid); end
    tests_run++; if (bus.mem_en !== 1'b0) begin tests_failed++; $display("FAIL fetch_mem_en_clr got %b want 0", bus.mem_en); end
    tick();
    tests_run++; if (bus.if_valid !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL fetch_end got valid=%b busy=%b want 0 0", bus.if_valid, bus.busy); end
  endtask

  task automatic test_write_read();
    push(1'b1, exp_dm);
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'h3FF; bus.dm_wdata = 32'h12345678;
    tick();
    tests_run++; if (bus.mem_we !== 1'b1) begin tests_failed++; $display("FAIL wr_mem_we got %b want 1", bus.mem_we); end
    tests_run++; if (bus.mem_addr !== 10'h3FF) begin tests_failed++; $display("FAIL wr_mem_addr got %h want 3ff", bus.mem_addr); end
    tests_run++; if (bus.mem_wdata !== 32'h12345678) begin tests_failed++; $display("FAIL wr_mem_wdata got %h want 12345678", bus.mem_wdata); end
    bus.dm_req = 1'b0;
    tick();
    tests_run++; if (bus.mem_we !== 1'b0) begin tests_failed++; $display("FAIL wr_mem_we_clr got %b want 0", bus.mem_we); end
    tests_run++; if (bus.mem_addr !== 10'h3FF) begin tests_failed++; $display("FAIL wr_addr_hold got %h want 3ff", bus.mem_addr); end
    tests_run++; if (bus.dm_valid !== 1'b1 || bus.dm_rdata !== exp_dm) begin tests_failed++; $display("FAIL wr_resp got valid=%b rdata=%h want 1 %h", bus.dm_valid, bus.dm_rdata, exp_dm); end
    tick();
    exp_dm = 32'h12345678;
    push(1'b1, exp_dm);
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_wdata = 32'h0;
    tick();
    bus.dm_req = 1'b0;
    tick();
    tests_run++; if (bus.dm_rdata !== 32'h12345678) begin tests_failed++; $display("FAIL rd_back got %h want 12345678", bus.dm_rdata); end
    tick();
  endtask

  task automatic test_contention();
    int n_valid;
    int last_t;
    bus.if_req = 1'b1; bus.if_addr = 10'd10;
    bus.dm_req = 1'b1; bus.dm_addr = 10'd20; bus.dm_we = 1'b0;
    push(1'b0, pat(10)); push(1'b1, pat(20)); push(1'b0, pat(10)); push(1'b1, pat(20));
    exp_dm  = pat(20);
    n_valid = 0;
    last_t  = -1;
    for (int t = 1; t <= 11; t++) begin
      tick();
      if (bus.if_valid === 1'b1 || bus.dm_valid === 1'b1) begin
        n_valid++;
        if (last_t >= 0) begin
          tests_run++;
          if (t - last_t != 3) begin tests_failed++; $display("FAIL rr_spacing got %0d want 3", t - last_t); end
        end
        last_t = t;
      end
      if (bus.if_valid === 1'b1) bus.if_req = 1'b0;
      else if (!bus.if_req && bus.busy === 1'b0) bus.if_req = 1'b1;
      if (bus.dm_valid === 1'b1) bus.dm_req = 1'b0;
      else if (!bus.dm_req && bus.busy === 1'b0) bus.dm_req = 1'b1;
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    tests_run++; if (n_valid != 4) begin tests_failed++; $display("FAIL rr_count got %0d want 4", n_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd30;
    tick();
    bus.dm_req = 1'b0;
    reset = 1'b1;
    tick();
    tests_run++; if (bus.dm_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_dm_valid got %b want 0", bus.dm_valid); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
    tests_run++; if (bus.dm_rdata !== '0) begin tests_failed++; $display("FAIL rmid_dm_rdata got %h want 0", bus.dm_rdata); end
    reset = 1'b0;
    exp_dm = '0;
    tick();
    tests_run++; if (bus.dm_valid !== 1'b0 || bus.mem_en !== 1'b0) begin tests_failed++; $display("FAIL rmid_after got valid=%b en=%b want 0 0", bus.dm_valid, bus.mem_en); end
    push(1'b0, pat(40));
    bus.if_req = 1'b1; bus.if_addr = 10'd40;
    tick();
    bus.if_req = 1'b0;
    tick();
    tests_run++; if (bus.if_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_fetch got %b want 1", bus.if_valid); end
    tick();
  endtask

  task automatic test_held_request();
    exp_dm = pat(50);
    push(1'b1, exp_dm); push(1'b1, exp_dm);
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd50;
    tick();
    tick();
    tick();
    tick();
    tests_run++; if (bus.mem_en !== 1'b1 || bus.busy !== 1'b1) begin tests_failed++; $display("FAIL held_second got en=%b busy=%b want 1 1", bus.mem_en, bus.busy); end
    bus.dm_req = 1'b0;
    tick();
    tests_run++; if (bus.dm_valid !== 1'b1) begin tests_failed++; $display("FAIL held_valid got %b want 1", bus.dm_valid); end
    tick();
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_dm       = '0;
    for (int i = 0; i < 1024; i++) ram[i] = pat(i);
    ram[5] = 32'hDEADBEEF;
    bus.mem_rdata = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    reset = 1'b1;

    test_reset();
    test_single_fetch();
    test_write_read();
    test_contention();
    test_reset_mid();
    test_held_request();

    tests_run++;
    if (sb.size() != 0) begin tests_failed++; $display("FAIL sb_drain got %0d pending want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
